// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode, load-use hazard detection
// and EX/MEM + MEM/WB operand forwarding for a classic 5-stage integer pipeline.
module id_ex_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic [1:0]       id_aluop,
  input  logic [5:0]       id_funct,
  input  logic             id_alusrc,
  input  logic             id_regdst,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_memtoreg,
  input  logic             flush,
  input  logic             exmem_regwrite,
  input  logic [4:0]       exmem_rd,
  input  logic [WIDTH-1:0] exmem_result,
  input  logic             memwb_regwrite,
  input  logic [4:0]       memwb_rd,
  input  logic [WIDTH-1:0] memwb_result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  output logic [WIDTH-1:0] ex_wdata,
  output logic [4:0]       ex_dst,
  output logic             ex_valid,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_memtoreg,
  output logic             stall
);

  logic             valid_q,    valid_d;
  logic             regwrite_q, regwrite_d;
  logic             memread_q,  memread_d;
  logic             memwrite_q, memwrite_d;
  logic             memtoreg_q, memtoreg_d;
  logic             alusrc_q,   alusrc_d;
  logic [2:0]       alu_sel_q,  alu_sel_d;
  logic [4:0]       dst_q,      dst_d;
  logic [4:0]       rs_q,       rs_d;
  logic [4:0]       rt_q,       rt_d;
  logic [WIDTH-1:0] rs_data_q,  rs_data_d;
  logic [WIDTH-1:0] rt_data_q,  rt_data_d;
  logic [WIDTH-1:0] imm_q,      imm_d;

  logic             bubble;
  logic [WIDTH-1:0] fwd_rs;
  logic [WIDTH-1:0] fwd_rt;

  // Load in EX whose destination is a source of the instruction in ID.
  always_comb begin
    stall = id_valid && valid_q && memread_q && (dst_q != 5'd0) &&
            ((dst_q == id_rs) || (dst_q == id_rt));
  end

  always_comb begin
    bubble = flush || stall || !id_valid;
  end

  always_comb begin
    alu_sel_d = 3'b010;
    case (id_aluop)
      2'b00: alu_sel_d = 3'b010;
      2'b01: alu_sel_d = 3'b110;
      2'b11: alu_sel_d = 3'b001;
      default: begin
        case (id_funct)
          6'b100000: alu_sel_d = 3'b010;
          6'b100010: alu_sel_d = 3'b110;
          6'b100100: alu_sel_d = 3'b000;
          6'b100101: alu_sel_d = 3'b001;
          6'b101010: alu_sel_d = 3'b111;
          default:   alu_sel_d = 3'b011;
        endcase
      end
    endcase
  end

  // Data fields are captured even for a bubble; only the controls are killed.
  always_comb begin
    valid_d    = id_valid    && !bubble;
    regwrite_d = id_regwrite && !bubble;
    memread_d  = id_memread  && !bubble;
    memwrite_d = id_memwrite && !bubble;
    memtoreg_d = id_memtoreg && !bubble;
    alusrc_d   = id_alusrc;
    dst_d      = id_regdst ? id_rd : id_rt;
    rs_d       = id_rs;
    rt_d       = id_rt;
    rs_data_d  = id_rs_data;
    rt_data_d  = id_rt_data;
    imm_d      = id_imm;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      alusrc_q   <= 1'b0;
      alu_sel_q  <= 3'b000;
      dst_q      <= 5'd0;
      rs_q       <= 5'd0;
      rt_q       <= 5'd0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      memtoreg_q <= memtoreg_d;
      alusrc_q   <= alusrc_d;
      alu_sel_q  <= alu_sel_d;
      dst_q      <= dst_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm_q      <= imm_d;
    end
  end

  // Nearer producer (EX/MEM) wins; $0 is never forwarded.
  always_comb begin
    if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rs_q))
      fwd_rs = exmem_result;
    else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rs_q))
      fwd_rs = memwb_result;
    else
      fwd_rs = rs_data_q;
  end

  always_comb begin
    if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rt_q))
      fwd_rt = exmem_result;
    else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rt_q))
      fwd_rt = memwb_result;
    else
      fwd_rt = rt_data_q;
  end

  always_comb begin
    alu_a       = fwd_rs;
    alu_b       = alusrc_q ? imm_q : fwd_rt;
    ex_wdata    = fwd_rt;
    alu_sel     = alu_sel_q;
    ex_dst      = dst_q;
    ex_valid    = valid_q;
    ex_regwrite = regwrite_q;
    ex_memread  = memread_q;
    ex_memwrite = memwrite_q;
    ex_memtoreg = memtoreg_q;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode, forwarding priority, load-use stall,
// flush/bubble handling and reset behaviour with hand-computed expectations.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [1:0]  id_aluop;
  logic [5:0]  id_funct;
  logic        id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic        flush;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_a, alu_b, ex_wdata;
  logic [2:0]  alu_sel;
  logic [4:0]  ex_dst;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, stall;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_aluop(id_aluop), .id_funct(id_funct),
    .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .flush(flush),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .ex_wdata(ex_wdata),
    .ex_dst(ex_dst), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .stall(stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 1'b0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_aluop = '0; id_funct = '0;
    id_alusrc = 1'b0; id_regdst = 1'b0; id_regwrite = 1'b0;
    id_memread = 1'b0; id_memwrite = 1'b0; id_memtoreg = 1'b0; flush = 1'b0;
    exmem_regwrite = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_regwrite = 1'b0; memwb_rd = '0; memwb_result = '0;
  endtask

  // R-type instruction: rd <- rs op rt
  task automatic set_rtype(input logic [5:0] funct, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd);
    id_valid = 1'b1; id_aluop = 2'b10; id_funct = funct;
    id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd;
    id_regdst = 1'b1; id_alusrc = 1'b0; id_regwrite = 1'b1;
    id_memread = 1'b0; id_memwrite = 1'b0; id_memtoreg = 1'b0;
  endtask

  // lw rt, imm(rs)
  task automatic set_lw(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm);
    id_valid = 1'b1; id_aluop = 2'b00; id_funct = '0;
    id_rs = rs; id_rt = rt; id_rd = '0; id_imm = imm;
    id_regdst = 1'b0; id_alusrc = 1'b1; id_regwrite = 1'b1;
    id_memread = 1'b1; id_memwrite = 1'b0; id_memtoreg = 1'b1;
  endtask

  logic [1:0] dec_op  [8] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
  logic [5:0] dec_fn  [8] = '{6'b100100, 6'b100000, 6'b101010, 6'b100000,
                              6'b100100, 6'b100101, 6'b101010, 6'b000000};
  logic [2:0] dec_exp [8] = '{3'b010, 3'b110, 3'b001, 3'b010, 3'b000, 3'b001, 3'b111, 3'b011};

  initial begin
    clear_inputs();
    reset = 1'b1;
    // reset overrides a valid instruction
    set_rtype(6'b100000, 5'd1, 5'd2, 5'd3, 32'd5, 32'd6);
    tick(); tick();
    check("rst_ex_valid",    ex_valid,    0);
    check("rst_ex_regwrite", ex_regwrite, 0);
    check("rst_ex_memread",  ex_memread,  0);
    check("rst_ex_memwrite", ex_memwrite, 0);
    check("rst_ex_memtoreg", ex_memtoreg, 0);
    check("rst_ex_dst",      ex_dst,      0);
    check("rst_alu_sel",     alu_sel,     0);
    check("rst_stall",       stall,       0);
    check("rst_alu_a",       alu_a,       0);
    reset = 1'b0;

    // R-type sub, 9 - 4
    clear_inputs();
    set_rtype(6'b100010, 5'd1, 5'd2, 5'd3, 32'd9, 32'd4);
    tick();
    check("sub_alu_sel",  alu_sel,     3'b110);
    check("sub_alu_a",    alu_a,       32'd9);
    check("sub_alu_b",    alu_b,       32'd4);
    check("sub_ex_valid", ex_valid,    1);
    check("sub_ex_dst",   ex_dst,      5'd3);
    check("sub_regwrite", ex_regwrite, 1);
    check("sub_wdata",    ex_wdata,    32'd4);

    // alu_sel decode table
    for (int i = 0; i < 8; i++) begin
      set_rtype(dec_fn[i], 5'd1, 5'd2, 5'd3, 32'd1, 32'd2);
      id_aluop = dec_op[i];
      tick();
      check($sformatf("dec_%0d", i), alu_sel, dec_exp[i]);
    end

    // I-type: regdst=0 selects rt, alusrc=1 selects imm, full-width operands
    set_lw(5'd4, 5'd7, 32'hFFFF_FFF8);
    id_memread = 1'b0; id_memtoreg = 1'b0; id_rs_data = 32'h8000_0001; id_rt_data = 32'h1234_5678;
    tick();
    check("itype_dst",   ex_dst,   5'd7);
    check("itype_alu_b", alu_b,    32'hFFFF_FFF8);
    check("itype_alu_a", alu_a,    32'h8000_0001);
    check("itype_wdata", ex_wdata, 32'h1234_5678);

    // forwarding priority: EX/MEM beats MEM/WB on both operands
    clear_inputs();
    set_rtype(6'b100000, 5'd5, 5'd5, 5'd6, 32'h33, 32'h44);
    tick();
    id_valid = 1'b0;
    exmem_regwrite = 1'b1; exmem_rd = 5'd5; exmem_result = 32'h77;
    memwb_regwrite = 1'b1; memwb_rd = 5'd5; memwb_result = 32'h11;
    #1;
    check("fwd_exmem_a",  alu_a,    32'h77);
    check("fwd_exmem_wd", ex_wdata, 32'h77);
    check("fwd_exmem_b",  alu_b,    32'h77);
    exmem_regwrite = 1'b0;
    #1;
    check("fwd_memwb_a",  alu_a,    32'h11);
    check("fwd_memwb_b",  alu_b,    32'h11);
    memwb_rd = 5'd9;
    #1;
    check("fwd_none_a",   alu_a,    32'h33);
    check("fwd_none_b",   alu_b,    32'h44);
    exmem_regwrite = 1'b1; exmem_rd = 5'd6;
    #1;
    check("fwd_rd_miss",  alu_a,    32'h33);

    // $0 never forwarded
    clear_inputs();
    set_rtype(6'b100000, 5'd0, 5'd0, 5'd6, 32'h0, 32'h0);
    tick();
    exmem_regwrite = 1'b1; exmem_rd = 5'd0; exmem_result = 32'h55;
    memwb_regwrite = 1'b1; memwb_rd = 5'd0; memwb_result = 32'h66;
    #1;
    check("zero_alu_a", alu_a,    32'h0);
    check("zero_wdata", ex_wdata, 32'h0);

    // load-use: lw $8 in EX, add reading $8 in ID
    clear_inputs();
    set_lw(5'd1, 5'd8, 32'd4);
    tick();
    check("lu_ex_memread", ex_memread, 1);
    check("lu_ex_dst",     ex_dst,     5'd8);
    set_rtype(6'b100000, 5'd8, 5'd9, 5'd10, 32'd1, 32'd2);
    #1;
    check("lu_stall", stall, 1);
    tick();
    check("lu_bub_valid",    ex_valid,    0);
    check("lu_bub_regwrite", ex_regwrite, 0);
    check("lu_stall_clear",  stall,       0);
    tick();
    check("lu_add_valid", ex_valid, 1);
    check("lu_add_dst",   ex_dst,   5'd10);
    check("lu_add_stall", stall,    0);

    // load into $0 never stalls
    set_lw(5'd1, 5'd0, 32'd4);
    tick();
    set_rtype(6'b100000, 5'd0, 5'd0, 5'd10, 32'd0, 32'd0);
    #1;
    check("lu_zero_stall", stall, 0);

    // flush and stall together: store reading loaded reg
    set_lw(5'd1, 5'd8, 32'd4);
    tick();
    id_valid = 1'b1; id_rs = 5'd2; id_rt = 5'd8; id_alusrc = 1'b1; id_regdst = 1'b0;
    id_regwrite = 1'b0; id_memread = 1'b0; id_memwrite = 1'b1; id_memtoreg = 1'b0;
    flush = 1'b1;
    #1;
    check("fs_stall", stall, 1);
    tick();
    check("fs_valid",    ex_valid,    0);
    check("fs_memwrite", ex_memwrite, 0);

    // flush alone on a hazard-free store
    flush = 1'b1; id_rt = 5'd3;
    tick();
    check("fl_valid",    ex_valid,    0);
    check("fl_memwrite", ex_memwrite, 0);
    flush = 1'b0;
    tick();
    check("st_memwrite", ex_memwrite, 1);
    check("st_valid",    ex_valid,    1);

    // id_valid=0 is a bubble
    id_valid = 1'b0;
    tick();
    check("idv0_valid",    ex_valid,    0);
    check("idv0_memwrite", ex_memwrite, 0);

    // reset mid-operation, then first instruction after release
    clear_inputs();
    set_lw(5'd1, 5'd12, 32'd8);
    tick();
    check("mr_pre_valid", ex_valid, 1);
    reset = 1'b1;
    tick();
    check("mr_valid",    ex_valid,    0);
    check("mr_memread",  ex_memread,  0);
    check("mr_memtoreg", ex_memtoreg, 0);
    check("mr_dst",      ex_dst,      0);
    check("mr_alu_sel",  alu_sel,     0);
    check("mr_alu_b",    alu_b,       0);
    reset = 1'b0;
    set_rtype(6'b100010, 5'd3, 5'd4, 5'd13, 32'd20, 32'd7);
    id_aluop = 2'b01;
    tick();
    check("mr_post_valid",   ex_valid, 1);
    check("mr_post_alu_sel", alu_sel,  3'b110);
    check("mr_post_dst",     ex_dst,   5'd13);
    check("mr_post_alu_a",   alu_a,    32'd20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
